// File: rtl/seq_detector_moore_param_pkg.sv
// Shared definitions for the programmable Moore sequence detector (package seq_det_pkg).
// State width helper, a wide state carrier type and the pattern-length clamp.
package seq_det_pkg;

  // Widest state encoding any instance may need; per-instance widths are derived from state_w().
  localparam int unsigned STATE_W_MAX = 16;

  typedef logic [STATE_W_MAX-1:0] state_t;

  // Bits needed to encode states 0..pat_w (state pat_w is the match state for full-length patterns).
  function automatic int unsigned state_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Lengths beyond the pattern register are clamped to its full width at load time.
  function automatic state_t clamp_len(input state_t len, input state_t pat_w);
    return (len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_detector_moore_param_if.sv
// Serial data, qualifier, configuration and result signals of the sequence detector.
// master = stream/config source, slave = detector.
interface seq_detector_moore_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int SW = state_w(PAT_W);

  logic             in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [SW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             out;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output in, in_valid, cfg_load, cfg_pat, cfg_len, cfg_overlap,
    input  out, hit_cnt
  );

  modport slave (
    input  in, in_valid, cfg_load, cfg_pat, cfg_len, cfg_overlap,
    output out, hit_cnt
  );

endinterface

// File: rtl/seq_detector_moore_param_next_state.sv
// Combinational prefix/suffix fallback for the sequence detector (module seq_det_next_state).
// Given the current partial-match length k and a new bit b, returns the longest
// pattern prefix that is a suffix of P[0..k-1]·b, capped at the pattern length.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  localparam int SW = state_w(PAT_W)
) (
  input  logic [SW-1:0]    k_i,
  input  logic             b_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [SW-1:0]    len_i,
  input  logic             ovl_i,
  output logic [SW-1:0]    nxt_o
);

  // Build S, then test every candidate prefix length; the longest hit wins.
  always_comb begin
    int              ke;
    int              ln;
    logic [PAT_W:0]  s;
    logic [PAT_W:0]  t;
    logic [PAT_W:0]  mask;
    ln    = int'(len_i);
    ke    = int'(k_i);
    // Non-overlapping mode restarts from scratch once a match completes.
    if (!ovl_i && (ke == ln)) ke = 0;
    s     = '0;
    for (int i = 0; i <= PAT_W; i++) begin
      if (i < PAT_W && i < ke) s[i] = pat_i[i];
      if (i == ke)             s[i] = b_i;
    end
    nxt_o = '0;
    t     = '0;
    mask  = '0;
    for (int j = 1; j <= PAT_W; j++) begin
      if ((j <= ke + 1) && (j <= ln)) begin
        // Align the last j bits of S to bit 0 and compare with P[0..j-1].
        t    = s >> (ke + 1 - j);
        mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - j);
        if (((t ^ {1'b0, pat_i}) & mask) == '0) nxt_o = SW'(j);
      end
    end
  end

endmodule

// File: rtl/seq_detector_moore_param.sv
// Runtime-programmable Moore serial sequence detector (1..PAT_W bit patterns,
// overlapping or non-overlapping, input qualifier). Optional saturating hit
// counter is built when SEQ_DET_HIT_COUNT_EN is defined; otherwise hit_cnt is 0.
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  seq_detector_moore_param_if.slave bus
);

  localparam int SW = state_w(PAT_W);
  localparam logic [SW-1:0] ST_IDLE = '0;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [SW-1:0]    len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [SW-1:0]    state_q, state_d;
  logic [SW-1:0]    nxt;
  logic             consume;

  seq_det_next_state #(.PAT_W(PAT_W)) u_next (
    .k_i   (state_q),
    .b_i   (bus.in),
    .pat_i (pat_q),
    .len_i (len_q),
    .ovl_i (ovl_q),
    .nxt_o (nxt)
  );

  // A bit advances the FSM only when qualified, not overridden by a load, and the detector is enabled.
  assign consume = bus.in_valid && !bus.cfg_load && (len_q != '0);

  // Config capture on load (which also restarts matching), otherwise advance on consumed bits.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    state_d = state_q;
    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pat;
      len_d   = SW'(clamp_len(state_t'(bus.cfg_len), state_t'(PAT_W)));
      ovl_d   = bus.cfg_overlap;
      state_d = ST_IDLE;
    end else if (consume) begin
      state_d = nxt;
    end
  end

  // Config and state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
      state_q <= ST_IDLE;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      state_q <= state_d;
    end
  end

  // Moore output: decoded purely from registered state.
  assign bus.out = (state_q == len_q) && (len_q != '0);

`ifdef SEQ_DET_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_match;

  // Every edge that lands in the match state counts, including a self-loop on it.
  assign enter_match = consume && (nxt == len_q);

  // Saturating hit counter, cleared by a config load.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cfg_load)                    cnt_d = '0;
    else if (enter_match && ~&cnt_q)     cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.hit_cnt = cnt_q;
`else
  assign bus.hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Directed scoreboard bench for seq_detector_moore_param (PAT_W=8, CNT_W=2).
// Expected out/hit_cnt are queued as each cycle is driven and popped after the edge.
// Hit-count expectations follow SEQ_DET_HIT_COUNT_EN (zero when it is undefined).
module tb_seq_detector_moore_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  seq_detector_moore_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_moore_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             out;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [CNT_W-1:0] ecnt(input int n);
`ifdef SEQ_DET_HIT_COUNT_EN
    return (n > 3) ? CNT_W'(3) : CNT_W'(n);
`else
    return (n > 0) ? '0 : '0;
`endif
  endfunction

  // Drive one clock's worth of inputs, queue the expectation, then compare after the edge.
  task automatic cycle(input logic rst, input logic ld, input logic b, input logic v,
                       input logic eo, input int en, input string tag);
    exp_t e;
    reset        = rst;
    bus.cfg_load = ld;
    bus.in       = b;
    bus.in_valid = v;
    sb.push_back('{eo, ecnt(en), tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.out === e.out) else begin
      errors++;
      $error("FAIL %s out: got %b expected %b", e.tag, bus.out, e.out);
    end
    checks++;
    assert (bus.hit_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s hit_cnt: got %0d expected %0d", e.tag, bus.hit_cnt, e.cnt);
    end
    reset        = 1'b0;
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [3:0] len, input logic ovl,
                      input string tag);
    bus.cfg_pat     = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic bit_in(input logic b, input logic eo, input int en, input string tag);
    cycle(1'b0, 1'b0, b, 1'b1, eo, en, tag);
  endtask

  task automatic gap(input logic eo, input int en, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, eo, en, tag);
  endtask

  initial begin
    bus.in = 1'b0; bus.in_valid = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b1;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset");

    // Reset config has len 0: detector is disabled.
    bit_in(1'b1, 1'b0, 0, "dis1");
    bit_in(1'b0, 1'b0, 0, "dis2");
    bit_in(1'b1, 1'b0, 0, "dis3");

    // Overlap, P=101 (bit0 first).
    load(8'h05, 4'd3, 1'b1, "ovl_load");
    bit_in(1'b1, 1'b0, 0, "ovl1");
    bit_in(1'b0, 1'b0, 0, "ovl2");
    bit_in(1'b1, 1'b1, 1, "ovl3");
    bit_in(1'b0, 1'b0, 1, "ovl4");
    bit_in(1'b1, 1'b1, 2, "ovl5");

    // Non-overlap, same pattern.
    load(8'h05, 4'd3, 1'b0, "nov_load");
    bit_in(1'b1, 1'b0, 0, "nov1");
    bit_in(1'b0, 1'b0, 0, "nov2");
    bit_in(1'b1, 1'b1, 1, "nov3");
    bit_in(1'b0, 1'b0, 1, "nov4");
    bit_in(1'b1, 1'b0, 1, "nov5");
    load(8'h05, 4'd3, 1'b0, "nov_reload");
    bit_in(1'b1, 1'b0, 0, "nob1");
    bit_in(1'b0, 1'b0, 0, "nob2");
    bit_in(1'b1, 1'b1, 1, "nob3");
    bit_in(1'b1, 1'b0, 1, "nob4");
    bit_in(1'b0, 1'b0, 1, "nob5");
    bit_in(1'b1, 1'b1, 2, "nob6");

    // Fallback: received order 1,1,0,1.
    load(8'h0B, 4'd4, 1'b1, "fb_load");
    bit_in(1'b1, 1'b0, 0, "fb1");
    bit_in(1'b1, 1'b0, 0, "fb2");
    bit_in(1'b1, 1'b0, 0, "fb3");
    bit_in(1'b0, 1'b0, 0, "fb4");
    bit_in(1'b1, 1'b1, 1, "fb5");
    bit_in(1'b0, 1'b0, 1, "fb6");

    // Qualifier gaps; out holds through idle cycles in the match state.
    load(8'h05, 4'd3, 1'b1, "q_load");
    bit_in(1'b1, 1'b0, 0, "q1");
    gap(1'b0, 0, "q_gap1a"); gap(1'b0, 0, "q_gap1b");
    bit_in(1'b0, 1'b0, 0, "q2");
    gap(1'b0, 0, "q_gap2a"); gap(1'b0, 0, "q_gap2b");
    bit_in(1'b1, 1'b1, 1, "q3");
    gap(1'b1, 1, "q_hold1"); gap(1'b1, 1, "q_hold2");
    bit_in(1'b0, 1'b0, 1, "q4");

    // cfg_load beats a final valid bit.
    load(8'h05, 4'd3, 1'b1, "pri_load");
    bit_in(1'b1, 1'b0, 0, "pri1");
    bit_in(1'b0, 1'b0, 0, "pri2");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, "pri_ld_bit");
    gap(1'b0, 0, "pri_after");

    // Reset mid-match discards the partial match and the config.
    bit_in(1'b1, 1'b0, 0, "rm1");
    bit_in(1'b0, 1'b0, 0, "rm2");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rm_reset");
    bit_in(1'b1, 1'b0, 0, "rm_nocfg");
    load(8'h05, 4'd3, 1'b1, "rm_load");
    bit_in(1'b1, 1'b0, 0, "rm3");
    bit_in(1'b0, 1'b0, 0, "rm4");
    bit_in(1'b1, 1'b1, 1, "rm5");

    // Length clamp: 15 loads as 8, all-ones pattern.
    load(8'hFF, 4'd15, 1'b1, "cl_load");
    for (int i = 0; i < 7; i++) bit_in(1'b1, 1'b0, 0, "cl_pre");
    bit_in(1'b1, 1'b1, 1, "cl8");
    bit_in(1'b1, 1'b1, 2, "cl9");

    // Single-bit pattern: continuous match and counter saturation.
    load(8'h01, 4'd1, 1'b1, "sat_load");
    bit_in(1'b1, 1'b1, 1, "sat1");
    bit_in(1'b1, 1'b1, 2, "sat2");
    bit_in(1'b1, 1'b1, 3, "sat3");
    bit_in(1'b1, 1'b1, 4, "sat4");
    bit_in(1'b1, 1'b1, 5, "sat5");
    bit_in(1'b0, 1'b0, 5, "sat_zero");
    bit_in(1'b1, 1'b1, 6, "sat6");
    load(8'h01, 4'd1, 1'b1, "sat_reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
